pc_call_stack: RTL and testbench
================================

# pc_call_stack

Parametrised program counter with a built-in subroutine return-address stack: the next-generation replacement for the fixed 12-bit PC of the nibble CPU. It holds the fetch address driving ROM, supports increment, absolute load, call (push return address + load) and return (pop). Address width and stack depth are parameters, and overflow/underflow are flagged so the micro-ROM decoder can trap them. It is driven by the same decoder strobes as the existing PC (`incPC`, `loadPC`) plus two new strobes (`call`, `ret`).

## Interface
- `ADDR_W`, 12: width of program address (2..16).
- `STACK_DEPTH`, 4: number of return-address entries (1..16).
- `RESET_ADDR`, 0: value of `addr` after reset; must fit in `ADDR_W`.

- `clk`  in  1  rising-edge clock for all state.
- `reset`  in  1  asynchronous, active-low reset (0 = in reset).
- `incPC`  in  1  advance `addr` by 1.
- `loadPC`  in  1  load `newaddr` into `addr`.
- `call`  in  1  push `addr+1`, load `newaddr`.
- `ret`  in  1  pop top entry into `addr`.
- `clr_err`  in  1  clear sticky `overflow`/`underflow`.
- `newaddr`  in  ADDR_W  jump/call target.
- `addr`  out  ADDR_W  current program address (registered).
- `depth`  out  clog2(STACK_DEPTH+1)  entries currently on stack (registered).
- `stack_empty`  out  1  `depth == 0`.
- `stack_full`  out  1  `depth == STACK_DEPTH`.
- `overflow`  out  1  sticky: a call was attempted while full.
- `underflow`  out  1  sticky: a ret was attempted while empty.

## Operation
- Exactly one command is executed per clock; priority `ret` > `call` > `loadPC` > `incPC`. Lower-priority strobes asserted in the same cycle are ignored entirely. No strobe: `addr` holds.
- `incPC`: `addr <= addr + 1` modulo 2^ADDR_W (all-ones wraps to 0).
- `loadPC`: `addr <= newaddr`.
- `call`, not full: `stack[depth] <= addr + 1` (mod 2^ADDR_W), `depth <= depth + 1`, `addr <= newaddr`.
- `call`, full: nothing pushed, `addr` and `depth` hold, `overflow <= 1`.
- `ret`, not empty: `addr <= stack[depth-1]`, `depth <= depth - 1`.
- `ret`, empty: `addr` and `depth` hold, `underflow <= 1`.
- Stack is LIFO indexed by `depth`; entries above `depth` are unspecified and never observable.
- `clr_err` clears both sticky flags; if an overflow/underflow event occurs in the same cycle, the event wins and its flag is 1 afterwards (the other flag clears).
- `stack_empty`/`stack_full` are combinational decodes of registered `depth` (no extra latency).

## Timing
- Reset (`reset`=0, asynchronous): `addr = RESET_ADDR`, `depth = 0`, `stack_empty = 1`, `stack_full = 0`, `overflow = 0`, `underflow = 0`; takes effect immediately, regardless of `clk`, including mid-call/ret. Stack RAM is not cleared.
- Reset release is sampled synchronously: first command accepted on the first rising edge with `reset`=1.
- All commands: latency 1 clock; `addr`, `depth`, flags update on the rising edge where the strobe is sampled high.
- Back-to-back `call`/`ret` every cycle is supported; a `ret` immediately after a `call` returns the address pushed by that call.
- `STACK_DEPTH = 1`: full and empty are mutually exclusive, depth toggles 0/1.
- Strobes are level-sampled; holding `incPC` high for N cycles advances `addr` by N.

## Test plan
(Defaults: ADDR_W=12, STACK_DEPTH=4, RESET_ADDR=0.)
- Reset then `incPC` held 3 cycles -> `addr` 0,1,2,3; `addr`=0xFFF + `incPC` -> 0x000; assert `reset`=0 between edges -> `addr`=0, `depth`=0 immediately.
- `loadPC` newaddr=0x123, then `call` newaddr=0x400 -> `addr`=0x400, `depth`=1; `ret` -> `addr`=0x124, `depth`=0, `stack_empty`=1.
- Nested: from 0x010 call 0x100, call 0x200, call 0x300, call 0x400 -> `depth`=4, `stack_full`=1; fifth call to 0x500 -> `addr` stays 0x400, `overflow`=1; four rets -> `addr` 0x301, 0x201, 0x101, 0x011.
- `ret` with empty stack at `addr`=0x050 -> `addr` stays 0x050, `underflow`=1; `clr_err` next cycle -> `underflow`=0; `clr_err` together with another empty `ret` -> `underflow`=1.
- Simultaneous strobes: `call`+`loadPC`+`incPC` at `addr`=0x020, newaddr=0x700 -> `addr`=0x700, `depth`+1, top=0x021; `ret`+`call` with depth 1 -> pop only, `depth`=0.
- Call at `addr`=0xFFF -> pushed return 0x000; subsequent `ret` -> `addr`=0x000; repeat with STACK_DEPTH=1, ADDR_W=8 instance for full/empty and 0xFF wrap.

Source files
------------

// File: rtl/pc_call_stack.sv
// Program counter with a LIFO return-address stack (increment, load, call, return).
// Latency: 1 clock for every command; addr/depth/flags are registered.
// Backpressure: none; one command per clock, overflow/underflow flagged sticky instead of stalling.
module pc_call_stack #(
    parameter int          ADDR_W      = 12,
    parameter int          STACK_DEPTH = 4,
    parameter int unsigned RESET_ADDR  = 0
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic                                   incPC_i,
    input  logic                                   loadPC_i,
    input  logic                                   call_i,
    input  logic                                   ret_i,
    input  logic                                   clr_err_i,
    input  logic [ADDR_W-1:0]                      newaddr_i,
    output logic [ADDR_W-1:0]                      addr_o,
    output logic [$clog2(STACK_DEPTH+1)-1:0]       depth_o,
    output logic                                   stack_empty_o,
    output logic                                   stack_full_o,
    output logic                                   overflow_o,
    output logic                                   underflow_o
);

    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;

    // Return-address storage; deliberately not reset, entries above depth are never read.
    logic [ADDR_W-1:0]  stack_q [STACK_DEPTH];

    logic [ADDR_W-1:0]  addr_inc;
    logic [ADDR_W-1:0]  top;
    logic               empty;
    logic               full;
    logic               push_en;
    logic               ovf_evt;
    logic               unf_evt;

    assign addr_inc = addr_q + 1'b1;
    assign empty    = (depth_q == '0);
    assign full     = (depth_q == DEPTH_W'(STACK_DEPTH));

    // Select the top-of-stack entry (stack[depth-1]) without an out-of-range index.
    always_comb begin
        top = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (depth_q == DEPTH_W'(i + 1)) begin
                top = stack_q[i];
            end
        end
    end

    // Next-state decode: ret > call > loadPC > incPC, lower strobes ignored entirely.
    always_comb begin
        addr_d  = addr_q;
        depth_d = depth_q;
        push_en = 1'b0;
        ovf_evt = 1'b0;
        unf_evt = 1'b0;
        if (ret_i) begin
            if (empty) begin
                unf_evt = 1'b1;
            end else begin
                addr_d  = top;
                depth_d = depth_q - 1'b1;
            end
        end else if (call_i) begin
            if (full) begin
                ovf_evt = 1'b1;
            end else begin
                push_en = 1'b1;
                addr_d  = newaddr_i;
                depth_d = depth_q + 1'b1;
            end
        end else if (loadPC_i) begin
            addr_d = newaddr_i;
        end else if (incPC_i) begin
            addr_d = addr_inc;
        end
        // A fault in the same cycle as clr_err must survive the clear.
        ovf_d = (ovf_q & ~clr_err_i) | ovf_evt;
        unf_d = (unf_q & ~clr_err_i) | unf_evt;
    end

    // Control state: address, stack depth and sticky error flags.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            addr_q  <= ADDR_W'(RESET_ADDR);
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Push the return address into the slot addressed by the current depth.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (push_en && depth_q == DEPTH_W'(i)) begin
                stack_q[i] <= addr_inc;
            end
        end
    end

    assign addr_o        = addr_q;
    assign depth_o       = depth_q;
    assign stack_empty_o = empty;
    assign stack_full_o  = full;
    assign overflow_o    = ovf_q;
    assign underflow_o   = unf_q;

endmodule

// File: tb/tb_pc_call_stack.sv
// Directed bench for pc_call_stack: default instance (12-bit, depth 4) and a small one (8-bit, depth 1).
module tb_pc_call_stack;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b0;

    // Default instance signals
    logic        inc, ld, call, ret, clr;
    logic [11:0] na;
    logic [11:0] addr;
    logic [2:0]  depth;
    logic        empty, full, ovf, unf;

    // Small instance signals
    logic        b_inc, b_ld, b_call, b_ret, b_clr;
    logic [7:0]  b_na;
    logic [7:0]  b_addr;
    logic [0:0]  b_depth;
    logic        b_empty, b_full, b_ovf, b_unf;

    int vectors = 0;
    int miscompares = 0;

    pc_call_stack #(.ADDR_W(12), .STACK_DEPTH(4), .RESET_ADDR(0)) dut_a (
        .clk_i(clk), .reset_i(reset), .incPC_i(inc), .loadPC_i(ld), .call_i(call),
        .ret_i(ret), .clr_err_i(clr), .newaddr_i(na), .addr_o(addr), .depth_o(depth),
        .stack_empty_o(empty), .stack_full_o(full), .overflow_o(ovf), .underflow_o(unf)
    );

    pc_call_stack #(.ADDR_W(8), .STACK_DEPTH(1), .RESET_ADDR(32'h10)) dut_b (
        .clk_i(clk), .reset_i(reset), .incPC_i(b_inc), .loadPC_i(b_ld), .call_i(b_call),
        .ret_i(b_ret), .clr_err_i(b_clr), .newaddr_i(b_na), .addr_o(b_addr), .depth_o(b_depth),
        .stack_empty_o(b_empty), .stack_full_o(b_full), .overflow_o(b_ovf), .underflow_o(b_unf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check the full status of the default instance.
    task automatic chk_a(input string tag, input logic [11:0] e_addr, input logic [2:0] e_depth,
                         input logic e_ovf, input logic e_unf);
        chk({tag, ".addr"},  32'(addr),  32'(e_addr));
        chk({tag, ".depth"}, 32'(depth), 32'(e_depth));
        chk({tag, ".empty"}, 32'(empty), 32'(e_depth == 3'd0));
        chk({tag, ".full"},  32'(full),  32'(e_depth == 3'd4));
        chk({tag, ".ovf"},   32'(ovf),   32'(e_ovf));
        chk({tag, ".unf"},   32'(unf),   32'(e_unf));
    endtask

    task automatic chk_b(input string tag, input logic [7:0] e_addr, input logic e_depth,
                         input logic e_ovf, input logic e_unf);
        chk({tag, ".addr"},  32'(b_addr),  32'(e_addr));
        chk({tag, ".depth"}, 32'(b_depth), 32'(e_depth));
        chk({tag, ".empty"}, 32'(b_empty), 32'(!e_depth));
        chk({tag, ".full"},  32'(b_full),  32'(e_depth));
        chk({tag, ".ovf"},   32'(b_ovf),   32'(e_ovf));
        chk({tag, ".unf"},   32'(b_unf),   32'(e_unf));
    endtask

    // Apply strobes to the default instance for one clock, sample #1 after the edge.
    task automatic step_a(input logic i_inc, input logic i_ld, input logic i_call,
                          input logic i_ret, input logic i_clr, input logic [11:0] i_na);
        inc = i_inc; ld = i_ld; call = i_call; ret = i_ret; clr = i_clr; na = i_na;
        @(posedge clk);
        #1;
        inc = 1'b0; ld = 1'b0; call = 1'b0; ret = 1'b0; clr = 1'b0;
    endtask

    task automatic step_b(input logic i_inc, input logic i_ld, input logic i_call,
                          input logic i_ret, input logic i_clr, input logic [7:0] i_na);
        b_inc = i_inc; b_ld = i_ld; b_call = i_call; b_ret = i_ret; b_clr = i_clr; b_na = i_na;
        @(posedge clk);
        #1;
        b_inc = 1'b0; b_ld = 1'b0; b_call = 1'b0; b_ret = 1'b0; b_clr = 1'b0;
    endtask

    initial begin
        inc = 0; ld = 0; call = 0; ret = 0; clr = 0; na = '0;
        b_inc = 0; b_ld = 0; b_call = 0; b_ret = 0; b_clr = 0; b_na = '0;

        // Reset state, both instances
        @(posedge clk); @(posedge clk); #1;
        chk_a("rst", 12'h000, 3'd0, 1'b0, 1'b0);
        chk_b("b_rst", 8'h10, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;

        // incPC held for 3 cycles
        inc = 1'b1;
        @(posedge clk); #1; chk("inc1", 32'(addr), 32'h001);
        @(posedge clk); #1; chk("inc2", 32'(addr), 32'h002);
        @(posedge clk); #1; chk("inc3", 32'(addr), 32'h003);
        inc = 1'b0;

        // All-ones wraps to zero
        step_a(0, 1, 0, 0, 0, 12'hFFF); chk("ld_fff", 32'(addr), 32'hFFF);
        step_a(1, 0, 0, 0, 0, 12'h000); chk("wrap", 32'(addr), 32'h000);

        // Async reset between edges while the stack holds an entry
        step_a(0, 1, 0, 0, 0, 12'h123);
        step_a(0, 0, 1, 0, 0, 12'h400); chk_a("pre_arst", 12'h400, 3'd1, 1'b0, 1'b0);
        #2 reset = 1'b0;
        #1 chk_a("arst", 12'h000, 3'd0, 1'b0, 1'b0);
        #1 reset = 1'b1;

        // Load, call, ret
        step_a(0, 1, 0, 0, 0, 12'h123); chk("ld123", 32'(addr), 32'h123);
        step_a(0, 0, 1, 0, 0, 12'h400); chk_a("call400", 12'h400, 3'd1, 1'b0, 1'b0);
        step_a(0, 0, 0, 1, 0, 12'h000); chk_a("ret124", 12'h124, 3'd0, 1'b0, 1'b0);

        // Nested calls to full, overflow, then unwind
        step_a(0, 1, 0, 0, 0, 12'h010);
        step_a(0, 0, 1, 0, 0, 12'h100); chk_a("n1", 12'h100, 3'd1, 1'b0, 1'b0);
        step_a(0, 0, 1, 0, 0, 12'h200); chk_a("n2", 12'h200, 3'd2, 1'b0, 1'b0);
        step_a(0, 0, 1, 0, 0, 12'h300); chk_a("n3", 12'h300, 3'd3, 1'b0, 1'b0);
        step_a(0, 0, 1, 0, 0, 12'h400); chk_a("n4", 12'h400, 3'd4, 1'b0, 1'b0);
        step_a(0, 0, 1, 0, 0, 12'h500); chk_a("ovf", 12'h400, 3'd4, 1'b1, 1'b0);
        // Overflow coinciding with clr_err keeps the flag set
        step_a(0, 0, 1, 0, 1, 12'h600); chk_a("ovf_clr", 12'h400, 3'd4, 1'b1, 1'b0);
        step_a(0, 0, 0, 1, 0, 12'h000); chk_a("r1", 12'h301, 3'd3, 1'b1, 1'b0);
        step_a(0, 0, 0, 1, 0, 12'h000); chk_a("r2", 12'h201, 3'd2, 1'b1, 1'b0);
        step_a(0, 0, 0, 1, 0, 12'h000); chk_a("r3", 12'h101, 3'd1, 1'b1, 1'b0);
        step_a(0, 0, 0, 1, 0, 12'h000); chk_a("r4", 12'h011, 3'd0, 1'b1, 1'b0);

        // Underflow and clear behaviour
        step_a(0, 1, 0, 0, 1, 12'h050); chk_a("clr_ovf", 12'h050, 3'd0, 1'b0, 1'b0);
        step_a(0, 0, 0, 1, 0, 12'h000); chk_a("unf", 12'h050, 3'd0, 1'b0, 1'b1);
        step_a(0, 0, 0, 0, 1, 12'h000); chk_a("clr_unf", 12'h050, 3'd0, 1'b0, 1'b0);
        step_a(0, 0, 0, 1, 1, 12'h000); chk_a("unf_clr", 12'h050, 3'd0, 1'b0, 1'b1);
        step_a(0, 0, 0, 0, 1, 12'h000); chk("clr2", 32'(unf), 32'h0);

        // Simultaneous strobes
        step_a(0, 1, 1'b0, 0, 0, 12'h020);
        step_a(1, 1, 1, 0, 0, 12'h700); chk_a("cli", 12'h700, 3'd1, 1'b0, 1'b0);
        step_a(0, 0, 1, 1, 0, 12'h555); chk_a("ret_call", 12'h021, 3'd0, 1'b0, 1'b0);
        step_a(1, 1, 0, 0, 0, 12'h0AB); chk("ld_over_inc", 32'(addr), 32'h0AB);

        // Call from 0xFFF pushes a wrapped return address
        step_a(0, 1, 0, 0, 0, 12'hFFF);
        step_a(0, 0, 1, 0, 0, 12'h123); chk_a("callwrap", 12'h123, 3'd1, 1'b0, 1'b0);
        step_a(0, 0, 0, 1, 0, 12'h000); chk_a("retwrap", 12'h000, 3'd0, 1'b0, 1'b0);

        // Depth-1, 8-bit instance
        step_b(0, 1, 0, 0, 0, 8'hFF);  chk("b_ld", 32'(b_addr), 32'hFF);
        step_b(0, 0, 1, 0, 0, 8'h40);  chk_b("b_call", 8'h40, 1'b1, 1'b0, 1'b0);
        step_b(0, 0, 1, 0, 0, 8'h60);  chk_b("b_ovf", 8'h40, 1'b1, 1'b1, 1'b0);
        step_b(0, 0, 0, 1, 0, 8'h00);  chk_b("b_ret", 8'h00, 1'b0, 1'b1, 1'b0);
        step_b(0, 0, 0, 1, 1, 8'h00);  chk_b("b_unf", 8'h00, 1'b0, 1'b0, 1'b1);
        step_b(0, 1, 0, 0, 0, 8'hFF);
        step_b(1, 0, 0, 0, 0, 8'h00);  chk("b_wrap", 32'(b_addr), 32'h00);
        step_b(0, 0, 1, 0, 0, 8'h33);  chk_b("b_call2", 8'h33, 1'b1, 1'b0, 1'b1);
        step_b(0, 0, 0, 1, 0, 8'h00);  chk_b("b_ret2", 8'h01, 1'b0, 1'b0, 1'b1);

        // Default instance stayed idle while the small one ran
        chk("a_idle", 32'(addr), 32'h000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
